// File: rtl/b16_sram_arb.sv
// b16_sram_arb: round-robin CPU/DMA arbiter and access sequencer for the
// asynchronous 16-bit eval-board SRAM. All SRAM-side outputs are registered.
//
// state  | meaning
// IDLE   | sample requests, arbitrate, latch the granted access
// SETUP  | address (and write data) driven, strobes high
// STROBE | rd_b or wr_b low for max(WAITS,1) cycles; read data captured on last edge
// HOLD   | strobes high, address/data held; ready or ack pulses
module b16_sram_arb #(
  parameter int l     = 16,
  parameter int WAITS = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [l-1:0] cpu_a,
  input  logic         cpu_r,
  input  logic [1:0]   cpu_w,
  input  logic [l-1:0] cpu_dout,
  output logic [l-1:0] cpu_din,
  output logic         cpu_ready,
  input  logic         dma_req,
  input  logic         dma_wr,
  input  logic [1:0]   dma_be,
  input  logic [l-1:0] dma_a,
  input  logic [l-1:0] dma_dout,
  output logic [l-1:0] dma_din,
  output logic         dma_ack,
  output logic [l-1:0] sram_a,
  output logic [l-1:0] sram_do,
  output logic         sram_oe,
  input  logic [l-1:0] sram_di,
  output logic         rd_b,
  output logic         wr_b,
  output logic         ble_b,
  output logic         bhe_b
);

  localparam int NW = (WAITS < 1) ? 1 : WAITS;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NW - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          gnt_dma, gnt_dma_nxt;
  logic          last_dma, last_dma_nxt;
  logic          wr_q, wr_nxt;
  logic [1:0]    be_q, be_nxt;
  logic          cpu_req;
  logic          grant;
  logic          sel_dma;
  logic          unused_a0;

  assign cpu_req   = cpu_r | (|cpu_w);
  assign unused_a0 = cpu_a[0] ^ dma_a[0];

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    gnt_dma_nxt  = gnt_dma;
    last_dma_nxt = last_dma;
    wr_nxt       = wr_q;
    be_nxt       = be_q;
    grant        = 1'b0;
    sel_dma      = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant        = 1'b1;
          // on a tie the side that did not win last time goes first
          sel_dma      = dma_req && (!cpu_req || !last_dma);
          gnt_dma_nxt  = sel_dma;
          last_dma_nxt = sel_dma;
          wr_nxt       = sel_dma ? dma_wr : (|cpu_w);
          be_nxt       = sel_dma ? dma_be : cpu_w;
          state_nxt    = SETUP;
        end
      end
      SETUP: begin
        cnt_nxt   = CNT_LOAD;
        state_nxt = STROBE;
      end
      STROBE: begin
        if (cnt == '0) state_nxt = HOLD;
        else           cnt_nxt   = cnt - 1'b1;
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt_dma   <= 1'b0;
      last_dma  <= 1'b1;
      wr_q      <= 1'b0;
      be_q      <= 2'b00;
      sram_a    <= '0;
      sram_do   <= '0;
      sram_oe   <= 1'b0;
      rd_b      <= 1'b1;
      wr_b      <= 1'b1;
      ble_b     <= 1'b1;
      bhe_b     <= 1'b1;
      cpu_ready <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_din   <= '0;
      dma_din   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gnt_dma  <= gnt_dma_nxt;
      last_dma <= last_dma_nxt;
      wr_q     <= wr_nxt;
      be_q     <= be_nxt;
      if (grant) begin
        sram_a <= {1'b0, (sel_dma ? dma_a[l-1:1] : cpu_a[l-1:1])};
        if (wr_nxt) sram_do <= sel_dma ? dma_dout : cpu_dout;
      end
      // outputs are decoded from the next state so the pins come straight from flops
      sram_oe   <= wr_nxt && (state_nxt != IDLE);
      rd_b      <= !((state_nxt == STROBE) && !wr_nxt);
      wr_b      <= !((state_nxt == STROBE) && wr_nxt);
      ble_b     <= !((state_nxt == STROBE) && (!wr_nxt || be_nxt[0]));
      bhe_b     <= !((state_nxt == STROBE) && (!wr_nxt || be_nxt[1]));
      cpu_ready <= (state_nxt == HOLD) && !gnt_dma_nxt;
      dma_ack   <= (state_nxt == HOLD) && gnt_dma_nxt;
      if ((state == STROBE) && (cnt == '0) && !wr_q) begin
        if (gnt_dma) dma_din <= sram_di;
        else         cpu_din <= sram_di;
      end
    end
  end

endmodule

// File: tb/tb_b16_sram_arb.sv
// Scoreboard bench for b16_sram_arb: a behavioural SRAM on the pins, per-requester
// expectation queues filled at issue time, and a negedge monitor that scores completions.
module tb_b16_sram_arb;
  localparam int NW = 2;

  typedef struct {
    logic        wr;
    logic [15:0] wa;
    logic [15:0] d;
    logic [1:0]  be;
  } acc_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] cpu_a, cpu_dout, cpu_din, dma_a, dma_dout, dma_din;
  logic [15:0] sram_a, sram_do, sram_di;
  logic [1:0]  cpu_w, dma_be;
  logic        cpu_r, cpu_ready, dma_req, dma_wr, dma_ack, sram_oe;
  logic        rd_b, wr_b, ble_b, bhe_b;

  logic [15:0] z_cpu_a, z_cpu_dout, z_cpu_din, z_dma_a, z_dma_dout, z_dma_din;
  logic [15:0] z_sram_a, z_sram_do, z_sram_di;
  logic [1:0]  z_cpu_w, z_dma_be;
  logic        z_cpu_r, z_cpu_ready, z_dma_req, z_dma_wr, z_dma_ack, z_sram_oe;
  logic        z_rd_b, z_wr_b, z_ble_b, z_bhe_b;

  b16_sram_arb #(.l(16), .WAITS(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_a(cpu_a), .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_be(dma_be), .dma_a(dma_a),
    .dma_dout(dma_dout), .dma_din(dma_din), .dma_ack(dma_ack),
    .sram_a(sram_a), .sram_do(sram_do), .sram_oe(sram_oe), .sram_di(sram_di),
    .rd_b(rd_b), .wr_b(wr_b), .ble_b(ble_b), .bhe_b(bhe_b)
  );

  b16_sram_arb #(.l(16), .WAITS(0)) dut0 (
    .clk(clk), .reset(reset),
    .cpu_a(z_cpu_a), .cpu_r(z_cpu_r), .cpu_w(z_cpu_w), .cpu_dout(z_cpu_dout),
    .cpu_din(z_cpu_din), .cpu_ready(z_cpu_ready),
    .dma_req(z_dma_req), .dma_wr(z_dma_wr), .dma_be(z_dma_be), .dma_a(z_dma_a),
    .dma_dout(z_dma_dout), .dma_din(z_dma_din), .dma_ack(z_dma_ack),
    .sram_a(z_sram_a), .sram_do(z_sram_do), .sram_oe(z_sram_oe), .sram_di(z_sram_di),
    .rd_b(z_rd_b), .wr_b(z_wr_b), .ble_b(z_ble_b), .bhe_b(z_bhe_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] initv(input int i);
    return 16'(i * 40503) ^ 16'h1234;
  endfunction

  // reference memory (model) and the pin-level SRAM the DUT talks to
  logic [15:0] ref_mem [0:1023];
  logic [15:0] mem [0:1023];
  int init_gen = 0;
  int mon_gen = 0;
  assign sram_di   = mem[sram_a[9:0]];
  assign z_sram_di = 16'hA5C3;

  acc_t cpu_q[$];
  acc_t dma_q[$];
  acc_t seen_q[$];
  int   pulse_cyc[$];
  bit   pulse_dma[$];

  acc_t cur;
  int wlow = 0, rlow = 0, z_rlow_total = 0;
  logic [15:0] last_cpu_din = '0, last_dma_din = '0;

  task automatic score(input bit is_dma, input logic [15:0] din);
    acc_t e, s;
    string who;
    who = is_dma ? "dma" : "cpu";
    if ((is_dma ? dma_q.size() : cpu_q.size()) == 0 || seen_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_done: completion at cycle %0d, pending seen=%0d expected none",
               who, cyc, seen_q.size());
    end else begin
      e = is_dma ? dma_q.pop_front() : cpu_q.pop_front();
      s = seen_q.pop_front();
      chk({who, "_dir"}, 32'(s.wr), 32'(e.wr));
      chk({who, "_addr"}, 32'(s.wa), 32'(e.wa));
      chk({who, "_be"}, 32'(s.be), 32'(e.be));
      if (e.wr) chk({who, "_wdata"}, 32'(s.d), 32'(e.d));
      else begin
        chk({who, "_rdata"}, 32'(din), 32'(e.d));
        if (is_dma) last_dma_din = e.d;
        else        last_cpu_din = e.d;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_gen != init_gen) begin
      for (int i = 0; i < 1024; i++) mem[i] = initv(i);
      mon_gen = init_gen;
    end
    if (!z_rd_b) z_rlow_total++;
    if (reset) begin
      wlow = 0;
      rlow = 0;
      last_cpu_din = '0;
      last_dma_din = '0;
    end else begin
      if (!wr_b) begin
        if (wlow == 0) begin
          cur.wr = 1'b1; cur.wa = sram_a; cur.d = sram_do; cur.be = {~bhe_b, ~ble_b};
        end
        chk("oe_during_write", 32'(sram_oe), 32'd1);
        wlow++;
      end else if (wlow != 0) begin
        chk("wr_b_width", wlow, NW);
        if (cur.be[0]) mem[cur.wa[9:0]][7:0]  = cur.d[7:0];
        if (cur.be[1]) mem[cur.wa[9:0]][15:8] = cur.d[15:8];
        seen_q.push_back(cur);
        wlow = 0;
      end
      if (!rd_b) begin
        if (rlow == 0) begin
          cur.wr = 1'b0; cur.wa = sram_a; cur.d = sram_di; cur.be = {~bhe_b, ~ble_b};
        end
        chk("oe_during_read", 32'(sram_oe), 32'd0);
        rlow++;
      end else if (rlow != 0) begin
        chk("rd_b_width", rlow, NW);
        seen_q.push_back(cur);
        rlow = 0;
      end
      if (cpu_ready && dma_ack) chk("ready_and_ack_together", 32'd1, 32'd0);
      if (cpu_ready) begin
        pulse_cyc.push_back(cyc);
        pulse_dma.push_back(1'b0);
        chk("dma_din_kept", 32'(dma_din), 32'(last_dma_din));
        score(1'b0, cpu_din);
      end
      if (dma_ack) begin
        pulse_cyc.push_back(cyc);
        pulse_dma.push_back(1'b1);
        chk("cpu_din_kept", 32'(cpu_din), 32'(last_cpu_din));
        score(1'b1, dma_din);
      end
    end
  end

  task automatic ref_write(input logic [15:0] wa, input logic [1:0] be, input logic [15:0] d);
    if (be[0]) ref_mem[wa[9:0]][7:0]  = d[7:0];
    if (be[1]) ref_mem[wa[9:0]][15:8] = d[15:8];
  endtask

  task automatic init_all();
    for (int i = 0; i < 1024; i++) ref_mem[i] = initv(i);
    init_gen++;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic cpu_op(input logic [15:0] a, input logic r, input logic [1:0] w,
                        input logic [15:0] d, input int reps, input bit lat);
    acc_t e;
    int n;
    e.wr = |w;
    e.wa = {1'b0, a[15:1]};
    e.be = e.wr ? w : 2'b11;
    if (e.wr) begin
      e.d = d;
      ref_write(e.wa, w, d);
    end else e.d = ref_mem[e.wa[9:0]];
    repeat (reps) cpu_q.push_back(e);
    @(posedge clk); #1;
    cpu_a = a; cpu_r = r; cpu_w = w; cpu_dout = d;
    for (int k = 0; k < reps; k++) begin
      n = 0;
      do begin
        @(posedge clk); n++; @(negedge clk);
      end while (!cpu_ready && n < 100);
      if (!cpu_ready) begin
        checks++; errors++;
        $display("FAIL cpu_timeout: no cpu_ready after %0d cycles, expected within %0d", n, NW + 2);
      end else if (lat && k == 0) chk("cpu_latency", n, NW + 2);
    end
    @(posedge clk); #1;
    cpu_r = 1'b0; cpu_w = 2'b00;
  endtask

  task automatic dma_op(input logic [15:0] a, input logic wr, input logic [1:0] be,
                        input logic [15:0] d, input int reps, input bit lat);
    acc_t e;
    int n;
    e.wr = wr;
    e.wa = {1'b0, a[15:1]};
    e.be = wr ? be : 2'b11;
    if (wr) begin
      e.d = d;
      ref_write(e.wa, be, d);
    end else e.d = ref_mem[e.wa[9:0]];
    repeat (reps) dma_q.push_back(e);
    @(posedge clk); #1;
    dma_a = a; dma_req = 1'b1; dma_wr = wr; dma_be = be; dma_dout = d;
    for (int k = 0; k < reps; k++) begin
      n = 0;
      do begin
        @(posedge clk); n++; @(negedge clk);
      end while (!dma_ack && n < 100);
      if (!dma_ack) begin
        checks++; errors++;
        $display("FAIL dma_timeout: no dma_ack after %0d cycles, expected within %0d", n, NW + 2);
      end else if (lat && k == 0) chk("dma_latency", n, NW + 2);
    end
    @(posedge clk); #1;
    dma_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    reset = 1'b1;
    cpu_a = '0; cpu_r = 1'b0; cpu_w = 2'b00; cpu_dout = '0;
    dma_a = '0; dma_req = 1'b0; dma_wr = 1'b0; dma_be = 2'b00; dma_dout = '0;
    z_cpu_a = '0; z_cpu_r = 1'b0; z_cpu_w = 2'b00; z_cpu_dout = '0;
    z_dma_a = '0; z_dma_req = 1'b0; z_dma_wr = 1'b0; z_dma_be = 2'b00; z_dma_dout = '0;
    init_all();

    chk("rst_strobes", 32'({rd_b, wr_b, ble_b, bhe_b}), 32'hF);
    chk("rst_oe", 32'(sram_oe), 32'd0);
    chk("rst_sram_a", 32'(sram_a), 32'd0);
    chk("rst_sram_do", 32'(sram_do), 32'd0);
    chk("rst_ready_ack", 32'({cpu_ready, dma_ack}), 32'd0);
    chk("rst_din", {cpu_din, dma_din}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    cpu_op(16'h4002, 1'b0, 2'b11, 16'hBEEF, 1, 1'b1);
    cpu_op(16'h4002, 1'b1, 2'b00, 16'h0000, 1, 1'b1);
    chk("cpu_din_beef", 32'(cpu_din), 32'hBEEF);
    cpu_op(16'h0040, 1'b1, 2'b01, 16'h33C4, 1, 1'b1);
    cpu_op(16'h0040, 1'b1, 2'b00, 16'h0000, 1, 1'b1);
    dma_op(16'h0402, 1'b1, 2'b10, 16'h12AB, 1, 1'b1);
    dma_op(16'h0402, 1'b0, 2'b00, 16'h0000, 1, 1'b1);
    dma_op(16'h0404, 1'b1, 2'b00, 16'hFFFF, 1, 1'b1);
    dma_op(16'h0404, 1'b0, 2'b11, 16'h0000, 1, 1'b0);

    // simultaneous requests straight out of reset
    do_reset();
    base = pulse_cyc.size();
    fork
      cpu_op(16'h0010, 1'b0, 2'b11, 16'h1357, 2, 1'b0);
      dma_op(16'h0420, 1'b0, 2'b00, 16'h0000, 1, 1'b0);
    join
    if (pulse_cyc.size() < base + 3) begin
      checks++; errors++;
      $display("FAIL rr_pulses: got %0d completions, expected 3", pulse_cyc.size() - base);
    end else begin
      chk("rr_order", 32'({pulse_dma[base], pulse_dma[base+1], pulse_dma[base+2]}), 32'b010);
      chk("rr_spacing1", pulse_cyc[base+1] - pulse_cyc[base], 5);
      chk("rr_spacing2", pulse_cyc[base+2] - pulse_cyc[base+1], 5);
    end

    // reset landing in the middle of a write strobe
    do_reset();
    @(posedge clk); #1;
    cpu_a = 16'h0060; cpu_w = 2'b11; cpu_dout = 16'hDEAD;
    n = 0;
    do begin @(negedge clk); n++; end while (wr_b && n < 20);
    chk("abort_wr_started", 32'(wr_b), 32'd0);
    reset = 1'b1;
    cpu_w = 2'b00;
    @(negedge clk);
    chk("abort_wr_b", 32'(wr_b), 32'd1);
    chk("abort_oe", 32'(sram_oe), 32'd0);
    chk("abort_no_ready", 32'({cpu_ready, dma_ack}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_quiet", 32'({cpu_ready, rd_b, wr_b, sram_oe}), 32'b0110);
    cpu_op(16'h0060, 1'b1, 2'b00, 16'h0000, 1, 1'b1);

    // single-wait build
    @(posedge clk); #1;
    z_cpu_a = 16'h0100; z_cpu_r = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk);
    end while (!z_cpu_ready && n < 20);
    chk("w0_latency", n, 3);
    chk("w0_rdata", 32'(z_cpu_din), 32'hA5C3);
    chk("w0_sram_a", 32'(z_sram_a), 32'h0080);
    @(posedge clk); #1 z_cpu_r = 1'b0;
    repeat (4) @(negedge clk);
    chk("w0_rd_b_width", z_rlow_total, 1);

    // randomized traffic, CPU and DMA in disjoint address windows
    init_all();
    do_reset();
    fork
      for (int i = 0; i < 30; i++) begin
        logic [1:0] w;
        logic r;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        w = 2'($urandom_range(0, 3));
        r = (w == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
        cpu_op({6'b0, 10'($urandom)}, r, w, 16'($urandom), 1, 1'b0);
      end
      for (int j = 0; j < 30; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        dma_op(16'h0400 | 16'(10'($urandom)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 16'($urandom), 1, 1'b0);
      end
    join

    repeat (5) @(negedge clk);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("dma_q_drained", dma_q.size(), 0);
    chk("seen_q_drained", seen_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
